// File: rtl/rr_mux_arb_4.sv
// rr_mux_arb_4: round-robin arbiter steering a shared 4:1 mux onto a valid/ready output,
// with a per-grant burst limit that forces rotation.
module rr_mux_arb_4 #(
  parameter int W = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [3:0]   Req,
  input  logic [W-1:0] In0,
  input  logic [W-1:0] In1,
  input  logic [W-1:0] In2,
  input  logic [W-1:0] In3,
  input  logic         OutReady,
  output logic [3:0]   Gnt,
  output logic [1:0]   Sel,
  output logic [W-1:0] Out,
  output logic         OutValid,
  output logic         Busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] ptr, nxt_ptr;
  logic [3:0] hold_cnt;
  logic [W-1:0] data [4];
  logic xfer, rel;
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [3:0] rot;
    logic [1:0] k;
    rot = 4'({r, r} >> p);
    k = 2'd0;
    for (int i = 3; i >= 0; i--) if (rot[i]) k = 2'(i);
    return p + k;
  endfunction
  assign data = '{In0, In1, In2, In3};
  assign Busy = state == GRANT;
  assign Gnt = Busy ? 4'b1 << Sel : 4'b0;
  assign OutValid = Busy & Req[Sel];
  assign Out = OutValid ? data[Sel] : '0;
  assign xfer = OutValid & OutReady;
  assign rel = Busy & (!Req[Sel] | (xfer & (hold_cnt == 4'(MAX_HOLD - 1))));
  assign nxt_ptr = Sel + 2'd1;
  // On release the old holder drops to lowest priority but can be re-granted with no bubble
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      ptr <= 2'd0;
      Sel <= 2'd0;
      hold_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (|Req) begin
        state <= GRANT;
        Sel <= pick(Req, ptr);
        hold_cnt <= 4'd0;
      end
    end else if (rel) begin
      ptr <= nxt_ptr;
      hold_cnt <= 4'd0;
      if (|Req) Sel <= pick(Req, nxt_ptr);
      else state <= IDLE;
    end else if (xfer) begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_rr_mux_arb_4.sv
// tb_rr_mux_arb_4: directed scenarios plus random traffic checked against a transfer-counting reference model.
module tb_rr_mux_arb_4;
  localparam int W = 8;
  localparam int MAX_HOLD = 4;
  logic Clk = 1'b0, Reset = 1'b1, OutReady = 1'b0;
  logic [3:0] Req = 4'b0;
  logic [W-1:0] in_v [4];
  logic [3:0] Gnt;
  logic [1:0] Sel;
  logic [W-1:0] Out;
  logic OutValid, Busy;
  int checks = 0, failures = 0;
  int m_g, m_ptr, m_sel, m_cnt, n_xfer;
  rr_mux_arb_4 #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .In0(in_v[0]), .In1(in_v[1]), .In2(in_v[2]), .In3(in_v[3]),
    .OutReady(OutReady), .Gnt(Gnt), .Sel(Sel), .Out(Out), .OutValid(OutValid), .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask
  function automatic int scan(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  // One clock: drive inputs, compare against the model, then advance the model across the edge.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic rdy);
    logic busy_e, ov_e;
    Reset = rst;
    Req = req;
    OutReady = rdy;
    #2;
    busy_e = m_g >= 0;
    ov_e = busy_e && req[m_g];
    chk("gnt", 32'(Gnt), busy_e ? 32'(1 << m_g) : 32'd0);
    chk("sel", 32'(Sel), 32'(m_sel));
    chk("busy", 32'(Busy), 32'(busy_e));
    chk("outvalid", 32'(OutValid), 32'(ov_e));
    chk("out", 32'(Out), ov_e ? 32'(in_v[m_g]) : 32'd0);
    if (rst) begin
      m_g = -1; m_ptr = 0; m_sel = 0; m_cnt = 0;
    end else if (m_g < 0) begin
      if (req != 0) begin m_g = scan(req, m_ptr); m_sel = m_g; m_cnt = 0; end
    end else begin
      if (ov_e && rdy) begin m_cnt++; n_xfer++; end
      if (!req[m_g] || m_cnt == MAX_HOLD) begin
        m_ptr = (m_g + 1) % 4;
        m_cnt = 0;
        m_g = scan(req, m_ptr);
        if (m_g >= 0) m_sel = m_g;
      end
    end
    @(posedge Clk);
    #1;
  endtask
  initial begin
    in_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(posedge Clk);
    #1;
    m_g = -1; m_ptr = 0; m_sel = 0; m_cnt = 0; n_xfer = 0;
    cyc(1, 4'b1111, 1);
    cyc(1, 4'b1111, 1);
    chk("rst_gnt", 32'(Gnt), 32'd0);
    chk("rst_sel", 32'(Sel), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    cyc(0, 4'b1111, 1);
    chk("first_gnt", 32'(Gnt), 32'b0001);
    for (int k = 0; k < 20; k++) begin
      chk("rotate_gnt", 32'(Gnt), 32'(1 << ((k / 4) % 4)));
      cyc(0, 4'b1111, 1);
    end
    cyc(1, 4'b0000, 1);
    in_v[2] = 8'hA5;
    cyc(0, 4'b0100, 1);
    chk("single_gnt", 32'(Gnt), 32'b0100);
    for (int k = 0; k < 8; k++) begin
      chk("single_out", 32'(Out), 32'hA5);
      chk("single_gnt_hold", 32'(Gnt), 32'b0100);
      cyc(0, 4'b0100, 1);
    end
    cyc(0, 4'b0000, 1);
    chk("single_idle", 32'(Busy), 32'd0);
    cyc(0, 4'b1111, 1);
    chk("ptr_after_release", 32'(Gnt), 32'b1000);
    cyc(1, 4'b0000, 0);
    in_v[1] = 8'h3C;
    cyc(0, 4'b0010, 0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_sel", 32'(Sel), 32'd1);
      chk("stall_out", 32'(Out), 32'h3C);
      cyc(0, 4'b0011, 0);
    end
    n_xfer = 0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_gnt", 32'(Gnt), 32'b0010);
      cyc(0, 4'b0011, 1);
    end
    chk("bp_xfers", 32'(n_xfer), 32'd4);
    chk("bp_next_gnt", 32'(Gnt), 32'b0001);
    cyc(1, 4'b0000, 1);
    cyc(0, 4'b1000, 1);
    chk("early_gnt3", 32'(Gnt), 32'b1000);
    cyc(0, 4'b1001, 1);
    cyc(0, 4'b1001, 1);
    cyc(0, 4'b0001, 1);
    chk("early_gnt0", 32'(Gnt), 32'b0001);
    chk("early_busy", 32'(Busy), 32'd1);
    cyc(0, 4'b0100, 1);
    cyc(0, 4'b0100, 1);
    cyc(1, 4'b0100, 1);
    chk("midrst_gnt", 32'(Gnt), 32'd0);
    cyc(0, 4'b1010, 1);
    chk("midrst_regrant", 32'(Gnt), 32'b0010);
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] r;
      for (int i = 0; i < 4; i++) in_v[i] = W'($urandom);
      r = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      cyc($urandom_range(0, 79) == 0, r, $urandom_range(0, 3) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_mux_arb_4.md
Name: rr_mux_arb_4

Overview:
Round-robin arbiter and sequencer for a shared 4:1 datapath mux. Four requesters each present a data word and a request. The block grants one requester at a time, drives the mux select, and forwards the selected word to a single downstream consumer over a valid/ready handshake. A per-grant burst limit (MAX_HOLD) bounds how long one requester can hold the mux, which guarantees fairness.

Parameters:
W, 8, width of each data input and of Out
MAX_HOLD, 4, maximum accepted transfers per grant before forced rotation; legal range 1..15

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Req  input  4  request from requester i (bit i); level-sensitive
In0  input  W  data word, requester 0
In1  input  W  data word, requester 1
In2  input  W  data word, requester 2
In3  input  W  data word, requester 3
OutReady  input  1  downstream accepts Out when high
Gnt  output  4  one-hot grant; all-zero when idle
Sel  output  2  registered mux select, index of granted requester
Out  output  W  selected data word; 0 when OutValid low
OutValid  output  1  Out holds valid data
Busy  output  1  high while in GRANT

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high.
- State: two-state FSM (IDLE, GRANT). Registers: Sel[1:0], Ptr[1:0] (round-robin start index), HoldCnt[3:0].
- Reset (Reset=1 at rising edge) sets: State=IDLE, Ptr=0, Sel=0, HoldCnt=0. Outputs are then Gnt=0000, Busy=0, OutValid=0, Out=0.
- Reset mid-grant: IDLE on that edge. Any handshake in the same cycle is discarded and does not count.
- Round-robin pick: scan Req starting at index Ptr, then Ptr+1, Ptr+2, Ptr+3 (mod 4). The first set bit wins.
- IDLE:
  - If Req != 0, the next edge enters GRANT with Sel=pick and HoldCnt=0.
  - Latency: Req sampled high -> Gnt asserted the following cycle.
  - Otherwise stay in IDLE.
- GRANT, combinational outputs:
  - Gnt = onehot(Sel); Busy=1.
  - OutValid = Req[Sel].
  - Out = In[Sel] when OutValid=1, else 0.
- Transfer occurs when OutValid & OutReady. Each transfer increments HoldCnt.
- Release conditions, evaluated in GRANT each cycle:
  - (a) Req[Sel]=0, so no transfer occurs that cycle; or
  - (b) a transfer occurs with HoldCnt == MAX_HOLD-1.
- On release:
  - Ptr <= Sel+1 (mod 4).
  - If the current Req, scanned from the new Ptr, is non-zero, go directly to GRANT with the new pick and HoldCnt=0. There is no idle bubble.
  - Otherwise go to IDLE.
- After a MAX_HOLD release, the previous holder has lowest priority. It is re-granted immediately if it is the sole requester.
- Stall: OutValid=1 and OutReady=0 holds Sel, HoldCnt and State. There is no timeout.
- Simultaneous events:
  - Req[Sel] falling while OutReady=1: no transfer, release via (a).
  - New Req bits rising during a grant have no effect until release.
- Sel and Gnt change only on clock edges. Gnt is never multi-hot.
- HoldCnt never exceeds MAX_HOLD-1.

Test Plan:
- Reset: hold Reset=1 for 2 cycles with Req=1111 -> Gnt=0000, Sel=0, OutValid=0, Out=0, Busy=0. First grant after release is Gnt=0001.
- Single requester, MAX_HOLD=4: Req=0100, In2=0xA5, OutReady=1 constantly.
  - Gnt=0100 one cycle after Req.
  - Four transfers of 0xA5, then re-grant of requester 2 with no IDLE cycle.
  - Ptr=3 after the first release.
- Fairness: Req=1111, OutReady=1.
  - Grants rotate 0001 -> 0010 -> 0100 -> 1000 -> 0001, each lasting exactly 4 transfers.
  - Out tracks In0..In3 accordingly.
- Backpressure: grant requester 1 with In1=0x3C, OutReady=0 for 5 cycles.
  - Sel=1, OutValid=1, Out=0x3C steady; HoldCnt=0 throughout.
  - After OutReady=1, exactly 4 transfers complete.
- Early release: grant requester 3, drop Req[3] after 2 transfers with Req[0]=1.
  - Next cycle Gnt=0001 and OutValid=Req[0]. No idle cycle.
- Reset mid-grant: Reset=1 during a transfer cycle.
  - Next cycle IDLE, Gnt=0000, Ptr=0.
  - Subsequent Req=1010 yields Gnt=0010.
